// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian signal controller: state encoding,
// default timing constants and a small state classification helper.
package ped_pkg;

  localparam int STATE_W = 3;

  // Controller states; encodings are fixed so debug probes stay readable.
  typedef enum logic [STATE_W-1:0] {
    IDLE     = 3'd0,
    WAIT_RED = 3'd1,
    WALK     = 3'd2,
    CLEAR    = 3'd3,
    FAULT    = 3'd4
  } ped_state_t;

  // Red-phase countdown value at or below which WALK gives way to clearance.
  localparam int CLEAR_CNT_DEF = 3;
  // Clock cycles per half-period of the flashing DONT_WALK lamp.
  localparam int FLASH_DIV_DEF = 4;

  // States in which DONT_WALK flashes instead of being steady.
  function automatic logic is_flashing(input ped_state_t s);
    return (s == CLEAR) || (s == FAULT);
  endfunction

endpackage

// File: rtl/ped_flash_gen.sv
// Flash timebase for the DONT_WALK lamp. A divider counts 0..FLASH_DIV-1
// and the phase toggles on each wrap. `restart` zeroes both so a new
// flashing interval always starts with the lamp lit.
// The flash_phase output is the phase value that will hold after the next
// clock edge, so the parent can register its lamp output in the same edge
// and stay aligned with the divider without an extra cycle of lag.
module ped_flash_gen
  import ped_pkg::*;
#(
  parameter int FLASH_DIV = FLASH_DIV_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic flash_phase
);

  localparam int DIV_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FLASH_DIV - 1);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] div_next;
  logic             phase_reg;
  logic             phase_next;

  // Next divider/phase: restart wins, otherwise count and toggle on wrap.
  always_comb begin
    div_next   = div_reg + 1'b1;
    phase_next = phase_reg;
    if (restart) begin
      div_next   = '0;
      phase_next = 1'b0;
    end else if (div_reg == DIV_LAST) begin
      div_next   = '0;
      phase_next = ~phase_reg;
    end
  end

  // Divider and phase registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg   <= '0;
      phase_reg <= 1'b0;
    end else begin
      div_reg   <= div_next;
      phase_reg <= phase_next;
    end
  end

  assign flash_phase = phase_next;

endmodule

// File: rtl/ped_signal_ctrl.sv
// Pedestrian crossing controller that follows the vehicle lights of an
// upstream traffic light controller. It latches button requests, grants
// WALK at the start of a sufficiently long red phase, flashes DONT_WALK
// during clearance, and drops into a flashing safe state whenever the
// upstream light combination is illegal.
// Optional build macro PED_COUNTDOWN_EN drives walk_cnt with a pedestrian
// countdown; without it walk_cnt is constant zero.
module ped_signal_ctrl
  import ped_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int CLEAR_CNT = CLEAR_CNT_DEF,
  parameter int FLASH_DIV = FLASH_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             green_light,
  input  logic             yellow_light,
  input  logic             red_light,
  input  logic [CNT_W-1:0] cnt,
  input  logic             ped_button,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending,
  output logic             fault,
  output logic [CNT_W-1:0] walk_cnt
);

  localparam logic [CNT_W-1:0] CLEAR_THR = CNT_W'(CLEAR_CNT);

  ped_state_t state_reg;
  ped_state_t state_next;
  logic       req_reg;
  logic       req_next;
  logic       red_d_reg;
  logic       btn_d_reg;
  logic       walk_reg;
  logic       dont_walk_reg;
  logic       fault_reg;

  logic       btn_rise;
  logic       red_rise;
  logic       legal;
  logic       cnt_above;
  logic       restart;
  logic       flash_phase;

  assign btn_rise  = ped_button & ~btn_d_reg;
  assign red_rise  = red_light & ~red_d_reg;
  // One-hot check: odd parity excludes 0 and 2 lamps, the AND excludes 3.
  assign legal     = (green_light ^ yellow_light ^ red_light) &
                     ~(green_light & yellow_light & red_light);
  // Enough red time remains for a useful WALK interval.
  assign cnt_above = (cnt > CLEAR_THR);

  // Transition and request-latch logic; an illegal light pattern overrides
  // everything and discards any pending request.
  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    if (!legal) begin
      state_next = FAULT;
      req_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (btn_rise) begin
            req_next   = 1'b1;
            state_next = WAIT_RED;
          end else if (req_reg) begin
            state_next = WAIT_RED;
          end
        end
        WAIT_RED: begin
          if (btn_rise) req_next = 1'b1;
          // A short red is skipped; the request waits for the next one.
          if (red_rise && cnt_above) begin
            state_next = WALK;
            req_next   = 1'b0;
          end
        end
        WALK: begin
          if (!red_light)      state_next = IDLE;
          else if (!cnt_above) state_next = CLEAR;
        end
        CLEAR: begin
          if (btn_rise)   req_next   = 1'b1;
          if (!red_light) state_next = IDLE;
        end
        FAULT: begin
          // Leaving during red could hand out a WALK mid-phase.
          if (!red_light) state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
          req_next   = 1'b0;
        end
      endcase
    end
  end

  // Each new flashing interval starts with DONT_WALK lit.
  assign restart = is_flashing(state_next) && (state_next != state_reg);

  ped_flash_gen #(
    .FLASH_DIV (FLASH_DIV)
  ) u_flash (
    .clk         (clk),
    .reset       (reset),
    .restart     (restart),
    .flash_phase (flash_phase)
  );

  // State, edge-detect history and lamp outputs, all decoded from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      req_reg       <= 1'b0;
      red_d_reg     <= 1'b0;
      btn_d_reg     <= 1'b0;
      walk_reg      <= 1'b0;
      dont_walk_reg <= 1'b1;
      fault_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      req_reg       <= req_next;
      red_d_reg     <= red_light;
      btn_d_reg     <= ped_button;
      walk_reg      <= (state_next == WALK);
      fault_reg     <= (state_next == FAULT);
      dont_walk_reg <= is_flashing(state_next) ? ~flash_phase
                                               : (state_next != WALK);
    end
  end

  assign walk        = walk_reg;
  assign dont_walk   = dont_walk_reg;
  assign req_pending = req_reg;
  assign fault       = fault_reg;

`ifdef PED_COUNTDOWN_EN
  logic [CNT_W-1:0] walk_cnt_reg;

  // Countdown display: time left in WALK, then raw countdown in clearance.
  always_ff @(posedge clk) begin
    if (reset) begin
      walk_cnt_reg <= '0;
    end else if (state_next == WALK) begin
      walk_cnt_reg <= cnt - CLEAR_THR;
    end else if (state_next == CLEAR) begin
      walk_cnt_reg <= cnt;
    end else begin
      walk_cnt_reg <= '0;
    end
  end

  assign walk_cnt = walk_cnt_reg;
`else
  assign walk_cnt = '0;
`endif

endmodule

// File: tb/tb_ped_signal_ctrl.sv
// Self-checking bench for ped_signal_ctrl: directed scenarios followed by a
// randomized upstream light sequence, all compared against a cycle-level
// reference model derived from the controller's rules.
module tb_ped_signal_ctrl;

  localparam int CNT_W     = 4;
  localparam int CLEAR_CNT = 3;
  localparam int FLASH_DIV = 4;

  localparam int S_IDLE  = 0;
  localparam int S_WAIT  = 1;
  localparam int S_WALK  = 2;
  localparam int S_CLEAR = 3;
  localparam int S_FAULT = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             green_light = 1'b1;
  logic             yellow_light = 1'b0;
  logic             red_light = 1'b0;
  logic [CNT_W-1:0] cnt = '0;
  logic             ped_button = 1'b0;
  logic             walk;
  logic             dont_walk;
  logic             req_pending;
  logic             fault;
  logic [CNT_W-1:0] walk_cnt;

  int checks = 0;
  int failures = 0;
  string cur_tag = "init";

  // Reference model state
  int m_st = S_IDLE;
  bit m_req = 0;
  bit m_red_d = 0;
  bit m_btn_d = 0;
  int m_age = 0;
  int m_walk_cnt = 0;

  always #5 clk = ~clk;

  ped_signal_ctrl #(
    .CNT_W     (CNT_W),
    .CLEAR_CNT (CLEAR_CNT),
    .FLASH_DIV (FLASH_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .green_light  (green_light),
    .yellow_light (yellow_light),
    .red_light    (red_light),
    .cnt          (cnt),
    .ped_button   (ped_button),
    .walk         (walk),
    .dont_walk    (dont_walk),
    .req_pending  (req_pending),
    .fault        (fault),
    .walk_cnt     (walk_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  function automatic void model_edge(bit rst, bit g, bit y, bit r, int c, bit b);
    bit btn_rise, red_rise, legal;
    int prev, nst;
    if (rst) begin
      m_st = S_IDLE; m_req = 0; m_red_d = 0; m_btn_d = 0; m_age = 0; m_walk_cnt = 0;
      return;
    end
    btn_rise = b && !m_btn_d;
    red_rise = r && !m_red_d;
    legal    = (int'(g) + int'(y) + int'(r)) == 1;
    prev = m_st;
    nst  = m_st;
    if (!legal) begin
      nst = S_FAULT; m_req = 0;
    end else if (m_st == S_IDLE) begin
      if (btn_rise) m_req = 1;
      if (m_req) nst = S_WAIT;
    end else if (m_st == S_WAIT) begin
      if (btn_rise) m_req = 1;
      if (red_rise && c > CLEAR_CNT) begin nst = S_WALK; m_req = 0; end
    end else if (m_st == S_WALK) begin
      if (!r) nst = S_IDLE;
      else if (c <= CLEAR_CNT) nst = S_CLEAR;
    end else if (m_st == S_CLEAR) begin
      if (btn_rise) m_req = 1;
      if (!r) nst = S_IDLE;
    end else begin
      if (!r) nst = S_IDLE;
    end
    if (nst == S_CLEAR || nst == S_FAULT) m_age = (prev != nst) ? 0 : m_age + 1;
`ifdef PED_COUNTDOWN_EN
    m_walk_cnt = (nst == S_WALK) ? c - CLEAR_CNT : (nst == S_CLEAR) ? c : 0;
`else
    m_walk_cnt = 0;
`endif
    m_btn_d = b;
    m_red_d = r;
    m_st = nst;
  endfunction

  task automatic check_all();
    bit flashing;
    bit exp_dw;
    flashing = (m_st == S_CLEAR) || (m_st == S_FAULT);
    exp_dw   = flashing ? (((m_age / FLASH_DIV) % 2) == 0) : (m_st != S_WALK);
    chk({cur_tag, ":walk"}, 32'(walk), 32'(m_st == S_WALK));
    chk({cur_tag, ":dont_walk"}, 32'(dont_walk), 32'(exp_dw));
    chk({cur_tag, ":req_pending"}, 32'(req_pending), 32'(m_req));
    chk({cur_tag, ":fault"}, 32'(fault), 32'(m_st == S_FAULT));
    chk({cur_tag, ":walk_cnt"}, 32'(walk_cnt), 32'(m_walk_cnt));
  endtask

  // One clock cycle: drive inputs, take the edge, update model, compare.
  task automatic step(input bit rst, input bit g, input bit y, input bit r, input int c, input bit b);
    reset = rst; green_light = g; yellow_light = y; red_light = r;
    cnt = CNT_W'(c); ped_button = b;
    @(posedge clk);
    model_edge(rst, g, y, r, c, b);
    #1;
    check_all();
    $display("cyc tag=%s rst=%0d gyr=%0d%0d%0d cnt=%0d btn=%0d -> walk=%0d dw=%0d req=%0d fault=%0d wcnt=%0d",
             cur_tag, rst, g, y, r, c, b, walk, dont_walk, req_pending, fault, walk_cnt);
  endtask

  // One upstream phase counting cnt from len-1 down to 0.
  task automatic phase(input bit g, input bit y, input bit r, input int len,
                       input int btn_at, input bit rand_btn);
    for (int i = len - 1; i >= 0; i--)
      step(0, g, y, r, i, (i == btn_at) || (rand_btn && $urandom_range(0, 7) == 0));
  endtask

  initial begin
    logic [2:0] bad [5];
    bad[0] = 3'b000; bad[1] = 3'b110; bad[2] = 3'b101; bad[3] = 3'b011; bad[4] = 3'b111;

    cur_tag = "reset";
    step(1, 1, 0, 0, 5, 0);
    step(1, 1, 0, 0, 5, 0);
    chk("reset:dont_walk_lit", 32'(dont_walk), 32'd1);
    step(0, 1, 0, 0, 5, 0);

    cur_tag = "service";
    phase(1, 0, 0, 6, 3, 0);
    chk("service:req_latched", 32'(req_pending), 32'd1);
    phase(0, 1, 0, 3, -1, 0);
    step(0, 0, 0, 1, 9, 0);
    chk("service:walk_latency", 32'(walk), 32'd1);
    chk("service:req_cleared", 32'(req_pending), 32'd0);
`ifdef PED_COUNTDOWN_EN
    chk("service:walk_cnt_first", 32'(walk_cnt), 32'd6);
`else
    chk("service:walk_cnt_zero", 32'(walk_cnt), 32'd0);
`endif
    cur_tag = "late_req";
    phase(0, 0, 1, 9, 1, 0);
    chk("late_req:latched_in_clear", 32'(req_pending), 32'd1);
    phase(1, 0, 0, 4, -1, 0);
    phase(0, 1, 0, 2, -1, 0);
    step(0, 0, 0, 1, 9, 0);
    chk("late_req:walk", 32'(walk), 32'd1);
    phase(0, 0, 1, 9, -1, 0);
    cur_tag = "long_clear";
    for (int k = 0; k < 12; k++) step(0, 0, 0, 1, 0, 0);

    cur_tag = "short_red";
    phase(1, 0, 0, 5, 2, 0);
    phase(0, 1, 0, 2, -1, 0);
    step(0, 0, 0, 1, 2, 0);
    chk("short_red:no_walk", 32'(walk), 32'd0);
    chk("short_red:req_kept", 32'(req_pending), 32'd1);
    phase(0, 0, 1, 2, -1, 0);
    phase(1, 0, 0, 4, -1, 0);
    phase(0, 1, 0, 2, -1, 0);
    step(0, 0, 0, 1, 4, 0);
    chk("short_red:edge_walk", 32'(walk), 32'd1);
    phase(0, 0, 1, 4, -1, 0);

    cur_tag = "no_req";
    for (int k = 0; k < 3; k++) begin
      phase(1, 0, 0, 6, -1, 0);
      phase(0, 1, 0, 3, -1, 0);
      phase(0, 0, 1, 10, -1, 0);
    end

    cur_tag = "fault";
    phase(1, 0, 0, 5, 2, 0);
    phase(0, 1, 0, 2, -1, 0);
    step(0, 0, 0, 1, 9, 0);
    step(0, 0, 0, 1, 8, 0);
    for (int k = 0; k < 5; k++) step(0, 1, 0, 1, 7 - k, 0);
    chk("fault:active", 32'(fault), 32'd1);
    chk("fault:walk_off", 32'(walk), 32'd0);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 1, 2, 0);
    chk("fault:red_holds", 32'(fault), 32'd1);
    step(0, 1, 0, 0, 5, 0);
    chk("fault:exit", 32'(fault), 32'd0);

    cur_tag = "reset_mid_walk";
    phase(1, 0, 0, 3, 1, 0);
    phase(0, 1, 0, 2, -1, 0);
    step(0, 0, 0, 1, 12, 0);
    step(0, 0, 0, 1, 11, 0);
    step(1, 0, 0, 1, 10, 0);
    chk("reset_mid_walk:walk", 32'(walk), 32'd0);
    chk("reset_mid_walk:dont_walk", 32'(dont_walk), 32'd1);
    phase(0, 0, 1, 10, -1, 0);

    cur_tag = "random";
    for (int rnd = 0; rnd < 40; rnd++) begin
      phase(1, 0, 0, $urandom_range(2, 7), -1, 1);
      if ($urandom_range(0, 5) == 0) begin
        int n;
        n = $urandom_range(1, 4);
        for (int k = 0; k < n; k++) begin
          logic [2:0] p;
          p = bad[$urandom_range(0, 4)];
          step(0, p[2], p[1], p[0], $urandom_range(0, 15), $urandom_range(0, 1) == 1);
        end
      end
      phase(0, 1, 0, $urandom_range(1, 3), -1, 1);
      phase(0, 0, 1, $urandom_range(1, 16), -1, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
